// File: rtl/pht_pkg.sv
// Shared types and helpers for the pattern-history table.
// Counter type, FSM state enum and saturating-update function.
package pht_pkg;

  localparam int IDX_W_DEF = 8;
  localparam int CTR_W_DEF = 2;
  localparam int SAT_W     = 16;

  typedef logic [CTR_W_DEF-1:0] ctr_t;

  typedef enum logic {
    PHT_INIT,
    PHT_RUN
  } pht_state_t;

  // Width-agnostic: callers zero-extend into SAT_W and truncate back.
  function automatic logic [SAT_W-1:0] sat_next(
    input logic [SAT_W-1:0] old,
    input logic             taken,
    input logic [SAT_W-1:0] max_v
  );
    if (taken && (old < max_v))
      return old + 1'b1;
    if (!taken && (old != '0))
      return old - 1'b1;
    return old;
  endfunction

endpackage

// File: rtl/pht_ctr_if.sv
// Predict/update port bundle of the pattern-history table.
// The master side is fetch/commit, the slave side is the table.
interface pht_ctr_if #(
  parameter int IDX_W = 8,
  parameter int CTR_W = 2
);
  import pht_pkg::*;

  logic             ready;
  logic             pred_valid;
  logic [IDX_W-1:0] pred_idx;
  logic [CTR_W-1:0] pred_ctr;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;

  modport master (
    input  ready, pred_ctr, pred_taken,
    output pred_valid, pred_idx,
    output upd_valid, upd_idx, upd_taken
  );

  modport slave (
    output ready, pred_ctr, pred_taken,
    input  pred_valid, pred_idx,
    input  upd_valid, upd_idx, upd_taken
  );

endinterface

// File: rtl/pht_mem_1w1r.sv
// Counter storage: one synchronous write port,
// two combinational read ports (predict and update stage).
module pht_mem_1w1r
  import pht_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [CTR_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr_a,
  output logic [CTR_W-1:0] rdata_a,
  input  logic [IDX_W-1:0] raddr_b,
  output logic [CTR_W-1:0] rdata_b
);

  logic [CTR_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pht_ctr_table.sv
// Parametrised PHT: init sweep, read-modify-write saturating
// counter update and same-cycle update-to-predict bypass.
module pht_ctr_table
  import pht_pkg::*;
#(
  parameter int IDX_W    = IDX_W_DEF,
  parameter int CTR_W    = CTR_W_DEF,
  parameter int INIT_VAL = (2**(CTR_W-1)) - 1
) (
  input  logic     clk,
  input  logic     rst,
  pht_ctr_if.slave io
);

  localparam int DEPTH   = 2**IDX_W;
  localparam int CTR_MAX = (2**CTR_W) - 1;
  localparam logic [CTR_W-1:0] INIT_C = CTR_W'(INIT_VAL);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(DEPTH - 1);

  pht_state_t       state_q, state_d;
  logic [IDX_W-1:0] sw_idx_q, sw_idx_d;
  logic             s1_vld_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_tkn_q;
  logic [IDX_W-1:0] pidx_q;

  logic             run;
  logic             hit;
  logic [CTR_W-1:0] rd_p, rd_s1, s1_next, pctr;
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [CTR_W-1:0] wdata;

  assign run = (state_q == PHT_RUN);
  assign hit = s1_vld_q && (s1_idx_q == pidx_q);

  always_comb begin
    state_d  = state_q;
    sw_idx_d = sw_idx_q;
    if (!run) begin
      sw_idx_d = sw_idx_q + 1'b1;
      if (sw_idx_q == LAST)
        state_d = PHT_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PHT_INIT;
      sw_idx_q <= '0;
      s1_vld_q <= 1'b0;
      pidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      sw_idx_q <= sw_idx_d;
      s1_vld_q <= run && io.upd_valid;
      if (run && io.upd_valid) begin
        s1_idx_q <= io.upd_idx;
        s1_tkn_q <= io.upd_taken;
      end
      if (run && io.pred_valid)
        pidx_q <= io.pred_idx;
    end
  end

  assign s1_next = CTR_W'(sat_next(SAT_W'(rd_s1), s1_tkn_q,
                                   SAT_W'(CTR_MAX)));

  // Sweep owns the write port in INIT, the update stage in RUN.
  assign we    = !run || s1_vld_q;
  assign waddr = run ? s1_idx_q : sw_idx_q;
  assign wdata = run ? s1_next : INIT_C;

  pht_mem_1w1r #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_mem (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (pidx_q),
    .rdata_a (rd_p),
    .raddr_b (s1_idx_q),
    .rdata_b (rd_s1)
  );

  always_comb begin
    pctr = rd_p;
    unique case (1'b1)
      !run:         pctr = INIT_C;
      run && hit:   pctr = s1_next;
      run && !hit:  pctr = rd_p;
      default:      pctr = rd_p;
    endcase
  end

  assign io.pred_ctr   = pctr;
  assign io.pred_taken = pctr[CTR_W-1];
  assign io.ready      = run;

endmodule

// File: tb/tb_pht_ctr_table.sv
// Directed bench for pht_ctr_table: default 256x2 instance
// plus a 16x3 instance for the parameter corner.
module tb_pht_ctr_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic rst_b = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  pht_ctr_if #(.IDX_W(8), .CTR_W(2)) bus ();
  pht_ctr_if #(.IDX_W(4), .CTR_W(3)) bus_b ();

  pht_ctr_table #(.IDX_W(8), .CTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  pht_ctr_table #(.IDX_W(4), .CTR_W(3)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .io  (bus_b)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_pred(input logic [7:0] idx);
    bus.pred_valid = 1'b1;
    bus.pred_idx   = idx;
    tick();
    bus.pred_valid = 1'b0;
  endtask

  task automatic drive_upd(input logic [7:0] idx, input logic tkn,
                           input int n);
    for (int k = 0; k < n; k++) begin
      bus.upd_valid = 1'b1;
      bus.upd_idx   = idx;
      bus.upd_taken = tkn;
      tick();
    end
    bus.upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 0", bus.ready);
    end
    n_chk++;
    if (bus.pred_ctr !== 2'd1 || bus.pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pred got %0d/%b want 1/0",
               bus.pred_ctr, bus.pred_taken);
    end
    for (int i = 1; i <= 256; i++) begin
      // predicts in INIT must be ignored
      bus.pred_valid = 1'b1;
      bus.pred_idx   = 8'(i);
      tick();
      exp = (i == 256);
      n_chk++;
      if (bus.ready !== exp) begin
        n_fail++;
        $display("FAIL init_ready edge %0d got %b want %b",
                 i, bus.ready, exp);
      end
    end
    bus.pred_valid = 1'b0;
  endtask

  task automatic test_predict_init();
    logic [7:0] idxs [3];
    idxs = '{8'd0, 8'd128, 8'd255};
    for (int i = 0; i < 3; i++) begin
      drive_pred(idxs[i]);
      n_chk++;
      if (bus.pred_ctr !== 2'd1 || bus.pred_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL init_val idx %0d got %0d/%b want 1/0",
                 idxs[i], bus.pred_ctr, bus.pred_taken);
      end
    end
  endtask

  task automatic test_sat_high();
    drive_upd(8'd5, 1'b1, 3);
    drive_pred(8'd5);
    n_chk++;
    if (bus.pred_ctr !== 2'd3) begin
      n_fail++;
      $display("FAIL inc_idx5 got %0d want 3", bus.pred_ctr);
    end
    drive_upd(8'd5, 1'b1, 2);
    drive_pred(8'd5);
    n_chk++;
    if (bus.pred_ctr !== 2'd3 || bus.pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_high got %0d/%b want 3/1",
               bus.pred_ctr, bus.pred_taken);
    end
  endtask

  task automatic test_bypass();
    bus.pred_valid = 1'b1;
    bus.pred_idx   = 8'd9;
    bus.upd_valid  = 1'b1;
    bus.upd_idx    = 8'd9;
    bus.upd_taken  = 1'b1;
    tick();
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
    n_chk++;
    if (bus.pred_ctr !== 2'd2 || bus.pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass got %0d/%b want 2/1",
               bus.pred_ctr, bus.pred_taken);
    end
    tick();
    n_chk++;
    if (bus.pred_ctr !== 2'd2) begin
      n_fail++;
      $display("FAIL bypass_hold got %0d want 2", bus.pred_ctr);
    end
    tick();
    drive_pred(8'd9);
    n_chk++;
    if (bus.pred_ctr !== 2'd2) begin
      n_fail++;
      $display("FAIL bypass_repeat got %0d want 2", bus.pred_ctr);
    end
  endtask

  task automatic test_sat_low();
    drive_upd(8'd7, 1'b0, 2);
    drive_pred(8'd7);
    n_chk++;
    if (bus.pred_ctr !== 2'd0) begin
      n_fail++;
      $display("FAIL dec_idx7 got %0d want 0", bus.pred_ctr);
    end
    drive_upd(8'd7, 1'b0, 1);
    drive_pred(8'd7);
    n_chk++;
    if (bus.pred_ctr !== 2'd0 || bus.pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_low got %0d/%b want 0/0",
               bus.pred_ctr, bus.pred_taken);
    end
    drive_pred(8'd8);
    n_chk++;
    if (bus.pred_ctr !== 2'd1) begin
      n_fail++;
      $display("FAIL neighbour_idx8 got %0d want 1", bus.pred_ctr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] idxs [3];
    logic [1:0] exps [3];
    // 1 -> 2 -> 3 -> 2 on consecutive edges
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 8'd20;
    bus.upd_taken = 1'b1;
    tick();
    tick();
    bus.upd_taken = 1'b0;
    tick();
    bus.upd_valid = 1'b0;
    drive_pred(8'd20);
    n_chk++;
    if (bus.pred_ctr !== 2'd2) begin
      n_fail++;
      $display("FAIL b2b_idx20 got %0d want 2", bus.pred_ctr);
    end
    idxs = '{8'd5, 8'd7, 8'd8};
    exps = '{2'd3, 2'd0, 2'd1};
    bus.pred_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pred_idx = idxs[i];
      tick();
      n_chk++;
      if (bus.pred_ctr !== exps[i]) begin
        n_fail++;
        $display("FAIL stream idx %0d got %0d want %0d",
                 idxs[i], bus.pred_ctr, exps[i]);
      end
    end
    bus.pred_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++)
      tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      exp = (i == 256);
      n_chk++;
      if (bus.ready !== exp) begin
        n_fail++;
        $display("FAIL midsweep_ready edge %0d got %b want %b",
                 i, bus.ready, exp);
      end
    end
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 8'd3;
    bus.upd_taken = 1'b1;
    tick();
    bus.upd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midupd_ready got %b want 0", bus.ready);
    end
    for (int i = 1; i <= 256; i++) begin
      tick();
      exp = (i == 256);
      n_chk++;
      if (bus.ready !== exp) begin
        n_fail++;
        $display("FAIL midupd_ready edge %0d got %b want %b",
                 i, bus.ready, exp);
      end
    end
    drive_pred(8'd3);
    n_chk++;
    if (bus.pred_ctr !== 2'd1) begin
      n_fail++;
      $display("FAIL dropped_upd_idx3 got %0d want 1", bus.pred_ctr);
    end
    drive_pred(8'd5);
    n_chk++;
    if (bus.pred_ctr !== 2'd1) begin
      n_fail++;
      $display("FAIL resweep_idx5 got %0d want 1", bus.pred_ctr);
    end
  endtask

  task automatic test_small();
    logic exp;
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    n_chk++;
    if (bus_b.pred_ctr !== 3'd3 || bus_b.pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL small_init got %0d/%b want 3/0",
               bus_b.pred_ctr, bus_b.pred_taken);
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = (i == 16);
      n_chk++;
      if (bus_b.ready !== exp) begin
        n_fail++;
        $display("FAIL small_ready edge %0d got %b want %b",
                 i, bus_b.ready, exp);
      end
    end
    bus_b.upd_valid = 1'b1;
    bus_b.upd_idx   = 4'd2;
    bus_b.upd_taken = 1'b1;
    for (int k = 0; k < 4; k++)
      tick();
    bus_b.upd_valid  = 1'b0;
    bus_b.pred_valid = 1'b1;
    bus_b.pred_idx   = 4'd2;
    tick();
    bus_b.pred_valid = 1'b0;
    n_chk++;
    if (bus_b.pred_ctr !== 3'd7 || bus_b.pred_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL small_sat got %0d/%b want 7/1",
               bus_b.pred_ctr, bus_b.pred_taken);
    end
  endtask

  initial begin
    bus.pred_valid   = 1'b0;
    bus.pred_idx     = '0;
    bus.upd_valid    = 1'b0;
    bus.upd_idx      = '0;
    bus.upd_taken    = 1'b0;
    bus_b.pred_valid = 1'b0;
    bus_b.pred_idx   = '0;
    bus_b.upd_valid  = 1'b0;
    bus_b.upd_idx    = '0;
    bus_b.upd_taken  = 1'b0;
    tick();
    test_reset();
    test_predict_init();
    test_sat_high();
    test_bypass();
    test_sat_low();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pht_ctr_table.md
# pht_ctr_table

Parametrised pattern-history table for the branch predictor in the out-of-order core's fetch stage. It generalises the fixed 256×2 PHT storage to any depth and counter width. It adds in-block saturating-counter update (read-modify-write), a post-reset initialisation sweep, and same-cycle update-to-predict bypass. It has one predict (read) port for fetch and one update port driven by branch resolution at commit.

## Interface
Parameters:
- IDX_W, 8: index width; DEPTH = 2**IDX_W entries.
- CTR_W, 2: counter width, ≥ 2; CTR_MAX = 2**CTR_W − 1.
- INIT_VAL, 2**(CTR_W−1) − 1: value every entry is set to by the sweep (weakly not-taken).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the init sweep completes; ports are ignored while low.
- pred_valid  in  1  sample pred_idx this edge.
- pred_idx  in  IDX_W  predict index.
- pred_ctr  out  CTR_W  counter for the last sampled pred_idx.
- pred_taken  out  1  pred_ctr MSB.
- upd_valid  in  1  accept an update this edge.
- upd_idx  in  IDX_W  update index.
- upd_taken  in  1  resolved direction.

## Operation
- FSM states:
  - INIT: sweep counter sw_idx writes INIT_VAL to mem[sw_idx] each cycle and increments it. At sw_idx == DEPTH−1 the state goes to RUN after that write.
  - RUN: ready = 1.
- rst in any state: state ← INIT, sw_idx ← 0, update stage S1 invalidated, pred_idx_q ← 0. Reset mid-sweep or mid-update restarts the sweep; the in-flight update is dropped.
- Predict:
  - In RUN, when pred_valid is high, pred_idx_q ← pred_idx.
  - pred_ctr is driven combinationally from mem[pred_idx_q], except when S1 is valid with S1.idx == pred_idx_q; then pred_ctr = S1's computed next value (bypass).
  - When pred_valid is low, pred_idx_q holds and pred_ctr tracks that entry.
  - In INIT, pred_ctr = INIT_VAL.
- Update:
  - In RUN, when upd_valid is high, S1 ← {idx, taken} and S1 is marked valid.
  - During the next cycle S1 reads mem[S1.idx] and computes the next value:
    - taken and old < CTR_MAX → old+1.
    - not taken and old > 0 → old−1.
    - otherwise old (saturates at both ends; no wrap).
  - The result is written at the following edge.
- Ordering rule: a prediction reflects every update whose upd_valid was sampled at or before the edge that sampled pred_idx.
- Back-to-back updates to the same index need no forwarding, since the write lands before the next S1 read. The bench checks this anyway.
- Predict and update to the same index in the same edge: the prediction sees the update, via the bypass.
- In INIT, upd_valid and pred_valid are ignored; no handshake back-pressure exists.

## Timing
- Reset values: ready = 0, pred_ctr = INIT_VAL, pred_taken = INIT_VAL[CTR_W−1], S1 invalid.
- ready rises at the DEPTH-th rising edge after the last edge with rst sampled high. For the defaults that is 256 cycles.
- Predict latency: 1 edge. pred_ctr is valid in the cycle after pred_valid is sampled.
- Update latency: 2 edges from acceptance to mem write; visible to predictions by bypass after 1 edge.
- Throughput: one predict and one update per cycle, sustained.

## Structure
- Shared package pht_pkg holds:
  - the ctr_t type (logic [CTR_W−1:0]), parameterised via localparams for the default width;
  - the FSM state enum pht_state_t {PHT_INIT, PHT_RUN};
  - the sat_next(old, taken) function.
- Sub-module pht_mem_1w1r: DEPTH×CTR_W array with one synchronous write port, one combinational read for predict and one for S1. The top level muxes the sweep and update writes into its single write port; these never conflict, since updates are ignored in INIT.

## Test plan
- Reset then idle:
  - ready stays 0 for 255 edges and is 1 at edge 256.
  - Predicting each of idx 0, 128 and 255 gives pred_ctr = 1, pred_taken = 0.
- Three taken updates to idx 5, then predict 5 → pred_ctr = 3. Two more taken updates → still 3 (saturation high).
- Predict 9 and update 9 (taken) on the same edge after init → pred_ctr = 2 in the next cycle (bypass); a repeat predict later → 2.
- Two not-taken updates to idx 7 → 0; a third → 0 (saturation low). Predict 8 → 1, no cross-entry disturbance.
- Reset asserted mid-sweep at cycle 100 and during a pending update to idx 3:
  - ready goes 0 and the sweep restarts, with ready rising 256 edges after rst drops;
  - idx 3 reads 1 afterwards.
- CTR_W = 3, IDX_W = 4:
  - ready after 16 edges, INIT_VAL = 3;
  - four taken updates to idx 2 → pred_ctr = 7, pred_taken = 1.
